// File: rtl/preg_pkg.sv
// Shared types and limits for the elastic pipeline register chain.
package preg_pkg;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} elastic_state_t;

  localparam int unsigned MAX_STAGES = 4;

  // Number of beats a stage holds in a given state.
  function automatic logic [1:0] beats_held(elastic_state_t s);
    case (s)
      BUSY:    beats_held = 2'd1;
      FULL:    beats_held = 2'd2;
      default: beats_held = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/preg_skid_stage.sv
// One elastic stage: main entry plus a skid entry, ready taken from state only.
module preg_skid_stage
  import preg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output elastic_state_t        state
);

  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  in_fire;
  logic                  out_fire;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // Skid always holds the younger beat, so it moves up on drain.
          if (out_fire) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/preg_elastic.sv
// Chain of STAGES elastic skid stages with flush and occupancy count.
module preg_elastic
  import preg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned OCC_W      = $clog2(2*STAGES+1)
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_flush,
  output logic [OCC_W-1:0]      o_occupancy
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("preg_elastic: STAGES must be in 1..MAX_STAGES");
  end

  logic                  valid [STAGES+1];
  logic                  ready [STAGES+1];
  logic [DATA_WIDTH-1:0] data  [STAGES+1];
  elastic_state_t        st    [STAGES];

  assign valid[0]      = i_valid;
  assign data[0]       = i_data;
  assign ready[STAGES] = i_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    preg_skid_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (i_clk),
      .rst_n    (i_arst_n),
      .flush    (i_flush),
      .in_valid (valid[k]),
      .in_ready (ready[k]),
      .in_data  (data[k]),
      .out_valid(valid[k+1]),
      .out_ready(ready[k+1]),
      .out_data (data[k+1]),
      .state    (st[k])
    );
  end

  assign o_ready = ready[0];
  assign o_valid = valid[STAGES];
  assign o_data  = data[STAGES];

  always_comb begin
    o_occupancy = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      o_occupancy = o_occupancy + OCC_W'(beats_held(st[k]));
    end
  end

endmodule
